// File: rtl/audio_sample_dma_writer_if.sv
// Control, Avalon-ST sink and Avalon-MM write-master signals of audio_sample_dma_writer.
// The master modport is the DMA block; the slave modport is its environment.
interface audio_sample_dma_writer_if #(
    parameter int LEN_W = 17
);
    logic             start;
    logic [15:0]      base_addr;
    logic [LEN_W-1:0] len_samples;
    logic             busy;
    logic             done;
    logic [15:0]      words_written;

    logic [15:0]      snk_data;
    logic             snk_valid;
    logic             snk_ready;

    logic [15:0]      avm_address;
    logic [3:0]       avm_byteenable;
    logic             avm_write;
    logic [31:0]      avm_writedata;
    logic             avm_waitrequest;

    modport master (
        input  start, base_addr, len_samples,
        input  snk_data, snk_valid, avm_waitrequest,
        output busy, done, words_written, snk_ready,
        output avm_address, avm_byteenable, avm_write, avm_writedata
    );

    modport slave (
        output start, base_addr, len_samples,
        output snk_data, snk_valid, avm_waitrequest,
        input  busy, done, words_written, snk_ready,
        input  avm_address, avm_byteenable, avm_write, avm_writedata
    );
endinterface

// File: rtl/audio_sample_dma_writer.sv
// Packs 16-bit audio sample pairs into 32-bit words and writes one frame to on-chip memory.
// Define SAMPLE_DMA_ODD_FLUSH_EN to flush an odd final sample as a half-word write.
module audio_sample_dma_writer #(
    parameter int LEN_W = 17
) (
    input logic                     clk,
    input logic                     reset_n,
    audio_sample_dma_writer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WRITE,
        TAIL,
        DONE
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [15:0]      address_r;
    logic [31:0]      data_r;
    logic [3:0]       be_r;
    logic             write_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [15:0]      words_r;
    logic             accept;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept = bus.snk_valid && ready_r;

    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.words_written  = words_r;
    assign bus.snk_ready      = ready_r;
    assign bus.avm_address    = address_r;
    assign bus.avm_byteenable = be_r;
    assign bus.avm_write      = write_r;
    assign bus.avm_writedata  = data_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            address_r <= '0;
            data_r    <= '0;
            be_r      <= '0;
            write_r   <= 1'b0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            words_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        address_r <= bus.base_addr;
                        remaining <= bus.len_samples;
                        words_r   <= '0;
                        busy_r    <= 1'b1;
                        if (bus.len_samples == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state   <= LO;
                            ready_r <= 1'b1;
                        end
                    end
                end

                LO: begin
                    if (accept) begin
                        data_r[15:0] <= bus.snk_data;
                        remaining    <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            ready_r <= 1'b0;
                            state   <= TAIL;
`ifdef SAMPLE_DMA_ODD_FLUSH_EN
                            data_r[31:16] <= '0;
                            be_r          <= 4'b0011;
                            write_r       <= 1'b1;
`endif
                        end else begin
                            state <= HI;
                        end
                    end
                end

                HI: begin
                    if (accept) begin
                        data_r[31:16] <= bus.snk_data;
                        remaining     <= remaining - LEN_ONE;
                        ready_r       <= 1'b0;
                        write_r       <= 1'b1;
                        be_r          <= 4'b1111;
                        state         <= WRITE;
                    end
                end

                // Address, data and byte lanes stay frozen until the slave stops stalling.
                WRITE: begin
                    if (!bus.avm_waitrequest) begin
                        write_r   <= 1'b0;
                        be_r      <= '0;
                        address_r <= address_r + 16'd1;
                        words_r   <= sat_inc16(words_r);
                        if (remaining == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state   <= LO;
                            ready_r <= 1'b1;
                        end
                    end
                end

                TAIL: begin
`ifdef SAMPLE_DMA_ODD_FLUSH_EN
                    if (!bus.avm_waitrequest) begin
                        write_r   <= 1'b0;
                        be_r      <= '0;
                        address_r <= address_r + 16'd1;
                        words_r   <= sat_inc16(words_r);
                        state     <= DONE;
                        done_r    <= 1'b1;
                    end
`else
                    // The odd final sample was consumed but is never written.
                    state  <= DONE;
                    done_r <= 1'b1;
`endif
                end

                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_dma_writer.sv
// Directed bench for audio_sample_dma_writer: frames, stalls, odd tail, wrap, zero length, restart, reset.
module tb_audio_sample_dma_writer;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    audio_sample_dma_writer_if #(.LEN_W(17)) bus ();

    audio_sample_dma_writer #(.LEN_W(17)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] src [8];
    int          src_n;
    int          src_idx;
    int          stall_left;

    logic [15:0] w_addr [8];
    logic [31:0] w_data [8];
    logic [3:0]  w_be   [8];
    int          wr_n;
    int          wr_seen;

    int          cyc;
    int          done_cnt;
    int          done_cyc;
    int          w1_cycles;
    int          hold_bad;
    logic [15:0] h_addr;
    logic [31:0] h_data;

    logic        post_busy;
    logic        post_ready;
    logic [15:0] post_words;
    logic        busy_after;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: note handshakes that complete at the edge, then update stimulus #1 after it.
    task automatic tick();
        logic acc;
        logic wacc;
        acc  = bus.snk_valid && bus.snk_ready;
        wacc = bus.avm_write && !bus.avm_waitrequest;
        if (bus.avm_write && bus.avm_waitrequest && stall_left > 0) stall_left--;
        if (wacc && wr_n < 8) begin
            w_addr[wr_n] = bus.avm_address;
            w_data[wr_n] = bus.avm_writedata;
            w_be[wr_n]   = bus.avm_byteenable;
            wr_n++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) src_idx++;
        bus.snk_valid       = (src_idx < src_n);
        bus.snk_data        = (src_idx < src_n) ? src[src_idx] : 16'h0000;
        bus.avm_waitrequest = bus.avm_write && (stall_left > 0);
        if (bus.avm_write) wr_seen++;
        if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (bus.avm_write && wr_n == 0) begin
            if (w1_cycles == 0) begin
                h_addr = bus.avm_address;
                h_data = bus.avm_writedata;
            end else if (bus.avm_address !== h_addr || bus.avm_writedata !== h_data || bus.snk_ready !== 1'b0) begin
                hold_bad++;
            end
            w1_cycles++;
        end
    endtask

    task automatic run_frame(input logic [15:0] base, input logic [16:0] len, input int nsamp,
                             input int stall, input int restart_at);
        src_n     = nsamp;
        src_idx   = 0;
        stall_left = stall;
        wr_n      = 0;
        wr_seen   = 0;
        cyc       = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        w1_cycles = 0;
        hold_bad  = 0;
        bus.snk_valid   = (nsamp > 0);
        bus.snk_data    = src[0];
        bus.base_addr   = base;
        bus.len_samples = len;
        bus.start       = 1'b1;
        tick();
        bus.start  = 1'b0;
        post_busy  = bus.busy;
        post_ready = bus.snk_ready;
        post_words = bus.words_written;
        for (int i = 0; i < 100 && done_cyc < 0; i++) begin
            if (cyc == restart_at) begin
                bus.start       = 1'b1;
                bus.base_addr   = 16'h0200;
                bus.len_samples = 17'd2;
            end
            tick();
            bus.start = 1'b0;
        end
        tick();
        busy_after = bus.busy;
        tick();
    endtask

    initial begin
        reset_n             = 1'b0;
        bus.start           = 1'b0;
        bus.base_addr       = 16'h0000;
        bus.len_samples     = 17'd0;
        bus.snk_data        = 16'h0000;
        bus.snk_valid       = 1'b0;
        bus.avm_waitrequest = 1'b0;
        src_n = 0; src_idx = 0; stall_left = 0; wr_n = 0; wr_seen = 0; cyc = 0;
        done_cnt = 0; done_cyc = -1; w1_cycles = 0; hold_bad = 0;
        h_addr = '0; h_data = '0;
        for (int i = 0; i < 8; i++) begin
            src[i] = '0; w_addr[i] = '0; w_data[i] = '0; w_be[i] = '0;
        end

        tick();
        tick();
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_ready", 32'(bus.snk_ready), 32'd0);
        check("rst_write", 32'(bus.avm_write), 32'd0);
        check("rst_addr",  32'(bus.avm_address), 32'd0);
        check("rst_be",    32'(bus.avm_byteenable), 32'd0);
        check("rst_data",  bus.avm_writedata, 32'd0);
        check("rst_words", 32'(bus.words_written), 32'd0);
        reset_n = 1'b1;
        tick();

        // Four-sample frame with one spare sample left unconsumed.
        src[0] = 16'h1111; src[1] = 16'h2222; src[2] = 16'h3333; src[3] = 16'h4444; src[4] = 16'h5555;
        run_frame(16'h0100, 17'd4, 5, 0, -1);
        check("f4_busy_n1",  32'(post_busy), 32'd1);
        check("f4_ready_n1", 32'(post_ready), 32'd1);
        check("f4_nwr",   wr_n, 2);
        check("f4_addr0", 32'(w_addr[0]), 32'h0100);
        check("f4_data0", w_data[0], 32'h22221111);
        check("f4_be0",   32'(w_be[0]), 32'hF);
        check("f4_addr1", 32'(w_addr[1]), 32'h0101);
        check("f4_data1", w_data[1], 32'h44443333);
        check("f4_be1",   32'(w_be[1]), 32'hF);
        check("f4_done_cyc", done_cyc, 7);
        check("f4_done_cnt", done_cnt, 1);
        check("f4_words", 32'(bus.words_written), 32'd2);
        check("f4_busy_after", 32'(busy_after), 32'd0);
        check("f4_consumed", src_idx, 4);

        // Same frame, first write stalled for three cycles.
        run_frame(16'h0100, 17'd4, 4, 3, -1);
        check("bp_w1_cycles", w1_cycles, 4);
        check("bp_hold_bad",  hold_bad, 0);
        check("bp_nwr",   wr_n, 2);
        check("bp_data0", w_data[0], 32'h22221111);
        check("bp_addr1", 32'(w_addr[1]), 32'h0101);
        check("bp_data1", w_data[1], 32'h44443333);
        check("bp_done_cyc", done_cyc, 10);
        check("bp_words", 32'(bus.words_written), 32'd2);

        // Odd length.
        src[0] = 16'hAAAA; src[1] = 16'hBBBB; src[2] = 16'hCCCC;
        run_frame(16'h0300, 17'd3, 3, 0, -1);
        check("odd_addr0", 32'(w_addr[0]), 32'h0300);
        check("odd_data0", w_data[0], 32'hBBBBAAAA);
        check("odd_done_cyc", done_cyc, 6);
        check("odd_consumed", src_idx, 3);
`ifdef SAMPLE_DMA_ODD_FLUSH_EN
        check("odd_nwr",   wr_n, 2);
        check("odd_addr1", 32'(w_addr[1]), 32'h0301);
        check("odd_data1", w_data[1], 32'h0000CCCC);
        check("odd_be1",   32'(w_be[1]), 32'h3);
        check("odd_words", 32'(bus.words_written), 32'd2);
`else
        check("odd_nwr",   wr_n, 1);
        check("odd_words", 32'(bus.words_written), 32'd1);
`endif

        // Address wrap.
        src[0] = 16'h1111; src[1] = 16'h2222; src[2] = 16'h3333; src[3] = 16'h4444;
        run_frame(16'hFFFF, 17'd4, 4, 0, -1);
        check("wrap_addr0", 32'(w_addr[0]), 32'hFFFF);
        check("wrap_addr1", 32'(w_addr[1]), 32'h0000);
        check("wrap_data1", w_data[1], 32'h44443333);

        // Zero length, samples offered but never taken.
        run_frame(16'h0400, 17'd0, 2, 0, -1);
        check("z_done_cyc", done_cyc, 1);
        check("z_write_cycles", wr_seen, 0);
        check("z_done_cnt", done_cnt, 1);
        check("z_consumed", src_idx, 0);
        check("z_words", 32'(bus.words_written), 32'd0);

        // Start pulse while busy is ignored.
        run_frame(16'h0100, 17'd4, 4, 0, 2);
        check("rs_nwr",   wr_n, 2);
        check("rs_addr0", 32'(w_addr[0]), 32'h0100);
        check("rs_addr1", 32'(w_addr[1]), 32'h0101);
        check("rs_done_cnt", done_cnt, 1);
        check("rs_busy_after", 32'(busy_after), 32'd0);

        // Reset while a write is stalled.
        src_n = 4; src_idx = 0; stall_left = 100; wr_n = 0; cyc = 0; done_cyc = -1;
        bus.snk_valid = 1'b1; bus.snk_data = src[0];
        bus.base_addr = 16'h0100; bus.len_samples = 17'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !bus.avm_write; i++) tick();
        check("mr_write_before", 32'(bus.avm_write), 32'd1);
        reset_n = 1'b0;
        tick();
        check("mr_write", 32'(bus.avm_write), 32'd0);
        check("mr_busy",  32'(bus.busy), 32'd0);
        check("mr_ready", 32'(bus.snk_ready), 32'd0);
        reset_n = 1'b1;
        stall_left = 0;
        bus.avm_waitrequest = 1'b0;
        tick();
        run_frame(16'h0300, 17'd4, 4, 0, -1);
        check("mr_post_words", 32'(post_words), 32'd0);
        check("mr_nwr",   wr_n, 2);
        check("mr_addr0", 32'(w_addr[0]), 32'h0300);
        check("mr_data0", w_data[0], 32'h22221111);
        check("mr_data1", w_data[1], 32'h44443333);
        check("mr_words", 32'(bus.words_written), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
